// File: rtl/myo_pwm_if.sv
// PID-to-H-bridge bundle for one motor channel.
interface myo_pwm_if;
  logic signed [15:0] pwmRef;
  logic               enable;
  logic               in_a;
  logic               in_b;
  logic               period_start;
  logic signed [15:0] duty_applied;

  modport master (
    output pwmRef, enable,
    input  in_a, in_b, period_start, duty_applied
  );

  modport slave (
    input  pwmRef, enable,
    output in_a, in_b, period_start, duty_applied
  );
endinterface

// File: rtl/myo_pwm_bridge.sv
// Slew-limited fixed-period PWM with reversal dead time,
// driving one H-bridge from a signed PID reference.
module myo_pwm_bridge #(
  parameter int PERIOD_CYCLES = 2500,
  parameter int DEAD_CYCLES   = 10,
  parameter int MAX_STEP      = 64
) (
  input  logic clock,
  input  logic reset,
  myo_pwm_if.slave bus
);

  typedef enum logic [1:0] {COAST, DRIVE, DEAD} state_e;
  typedef enum logic [1:0] {D_NONE, D_FWD, D_REV} dir_e;

  localparam logic [15:0] LAST = 16'(PERIOD_CYCLES - 1);
  localparam logic signed [16:0] STEP = 17'(MAX_STEP);
  localparam logic [16:0] PMAX = 17'(PERIOD_CYCLES);
  localparam logic [16:0] DEADC = 17'(DEAD_CYCLES);

  logic               run_q;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [15:0] applied_q, applied_d;
  dir_e               dir_q, dir_d;
  logic               rev_q, rev_d;
  state_e             state_q, state_d;
  logic               in_a_q, in_a_d;
  logic               in_b_q, in_b_d;
  logic               ps_q, ps_d;

  logic               bnd;
  logic signed [16:0] diff;
  logic signed [16:0] step_v;
  logic signed [15:0] new_app;
  logic [16:0]        ext;
  logic [16:0]        mag;
  logic [16:0]        duty;
  logic [16:0]        cnt_x;

  // run_q lets the first edge after reset enter cnt==0 without an update
  always_comb begin
    bnd    = run_q && (cnt_q == LAST);
    cnt_d  = (!run_q || bnd) ? 16'd0 : cnt_q + 16'd1;
    cnt_x  = {1'b0, cnt_d};
    diff   = $signed({bus.pwmRef[15], bus.pwmRef})
           - $signed({applied_q[15], applied_q});
    step_v = diff;
    if (diff > STEP)
      step_v = STEP;
    else if (diff < -STEP)
      step_v = -STEP;
    new_app = applied_q + 16'(step_v);

    applied_d = applied_q;
    dir_d     = dir_q;
    rev_d     = rev_q;
    if (!bus.enable) begin
      applied_d = '0;
      dir_d     = D_NONE;
      rev_d     = 1'b0;
    end else if (bnd) begin
      applied_d = new_app;
      rev_d     = 1'b0;
      if (new_app != 16'sd0) begin
        dir_d = new_app[15] ? D_REV : D_FWD;
        rev_d = (dir_q != D_NONE) && (dir_d != dir_q);
      end
    end

    ext  = {applied_d[15], applied_d};
    mag  = ext[16] ? (~ext + 17'd1) : ext;
    duty = (mag > PMAX) ? PMAX : mag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      applied_q <= '0;
      dir_q     <= D_NONE;
      rev_q     <= 1'b0;
      state_q   <= COAST;
    end else begin
      run_q     <= 1'b1;
      cnt_q     <= cnt_d;
      applied_q <= applied_d;
      dir_q     <= dir_d;
      rev_q     <= rev_d;
      state_q   <= state_d;
    end
  end

  // State for the cycle being entered, so outputs stay registered
  always_comb begin
    state_d = state_q;
    if (!bus.enable || applied_d == 16'sd0)
      state_d = COAST;
    else if (rev_d && cnt_x < DEADC)
      state_d = DEAD;
    else if (cnt_x < duty)
      state_d = DRIVE;
    else
      state_d = COAST;
  end

  always_comb begin
    in_a_d = 1'b0;
    in_b_d = 1'b0;
    ps_d   = (cnt_d == 16'd0);
    unique case (state_d)
      DRIVE: begin
        in_a_d = !applied_d[15];
        in_b_d = applied_d[15];
      end
      DEAD:    ;
      COAST:   ;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_a_q <= 1'b0;
      in_b_q <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      in_a_q <= in_a_d;
      in_b_q <= in_b_d;
      ps_q   <= ps_d;
    end
  end

  assign bus.in_a         = in_a_q;
  assign bus.in_b         = in_b_q;
  assign bus.period_start = ps_q;
  assign bus.duty_applied = applied_q;

endmodule

// File: tb/tb_myo_pwm_bridge.sv
// Directed per-period checks of myo_pwm_bridge.
module tb_myo_pwm_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  myo_pwm_if b1 ();
  myo_pwm_if b2 ();

  myo_pwm_bridge #(
    .PERIOD_CYCLES(100), .DEAD_CYCLES(5), .MAX_STEP(64)
  ) dut1 (.clock(clk), .reset(rst), .bus(b1.slave));

  myo_pwm_bridge #(
    .PERIOD_CYCLES(100), .DEAD_CYCLES(5), .MAX_STEP(32767)
  ) dut2 (.clock(clk), .reset(rst), .bus(b2.slave));

  typedef struct {
    logic signed [15:0] rf;
    logic               en;
    int                 duty;
    int                 ha;
    int                 hb;
    int                 first;
  } vec_t;

  vec_t tv [20];
  int npass = 0;
  int ntot  = 0;

  int ha, hb, first, ps_ok, ovl, ha2, hb2;
  int d1, d2;

  task automatic check(string nm, int row, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s row %0d: got %0d, expected %0d",
                  nm, row, act, exp);
  endtask

  task automatic run_period();
    ha = 0; hb = 0; first = 255; ps_ok = 1; ovl = 0;
    ha2 = 0; hb2 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        d1 = int'(b1.duty_applied);
        d2 = int'(b2.duty_applied);
      end
      if (b1.in_a) ha++;
      if (b1.in_b) hb++;
      if ((b1.in_a || b1.in_b) && first == 255) first = k;
      if (b1.period_start != (k == 0)) ps_ok = 0;
      if (b1.in_a && b1.in_b) ovl = 1;
      if (b2.in_a) ha2++;
      if (b2.in_b) hb2++;
      if (b2.in_a && b2.in_b) ovl = 1;
    end
  endtask

  int e2d [3];
  int e2b [3];
  int cnt_a, quiet;

  initial begin
    tv[0]  = '{16'sd40,   1'b1, 0,   0,   0,  255};
    tv[1]  = '{16'sd40,   1'b1, 40,  40,  0,  0};
    tv[2]  = '{16'sd40,   1'b1, 40,  40,  0,  0};
    tv[3]  = '{-16'sd40,  1'b1, -24, 0,   19, 5};
    tv[4]  = '{-16'sd40,  1'b1, -40, 0,   40, 0};
    tv[5]  = '{16'sd40,   1'b1, 24,  19,  0,  5};
    tv[6]  = '{16'sd40,   1'b1, 40,  40,  0,  0};
    tv[7]  = '{16'sd40,   1'b1, 40,  0,   0,  0};
    tv[8]  = '{16'sd40,   1'b1, 40,  40,  0,  0};
    tv[9]  = '{16'sd200,  1'b0, 0,   0,   0,  255};
    tv[10] = '{16'sd200,  1'b1, 64,  64,  0,  0};
    tv[11] = '{16'sd200,  1'b1, 128, 100, 0,  0};
    tv[12] = '{16'sd200,  1'b1, 192, 100, 0,  0};
    tv[13] = '{16'sd200,  1'b1, 200, 100, 0,  0};
    tv[14] = '{16'sd0,    1'b1, 136, 100, 0,  0};
    tv[15] = '{16'sd0,    1'b1, 72,  72,  0,  0};
    tv[16] = '{16'sd0,    1'b1, 8,   8,   0,  0};
    tv[17] = '{16'sd0,    1'b1, 0,   0,   0,  255};
    tv[18] = '{-16'sd10,  1'b1, -10, 0,   5,  5};
    tv[19] = '{-16'sd10,  1'b1, -10, 0,   10, 0};
    e2d = '{0, -32767, -32768};
    e2b = '{0, 100, 100};

    b1.pwmRef = 16'sd500;
    b1.enable = 1'b1;
    b2.pwmRef = -16'sd32768;
    b2.enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_a", -1, int'(b1.in_a), 0);
    check("rst_in_b", -1, int'(b1.in_b), 0);
    check("rst_duty", -1, int'(b1.duty_applied), 0);
    check("rst_pstart", -1, int'(b1.period_start), 0);
    b1.pwmRef = 16'sd40;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      b1.pwmRef = tv[i].rf;
      b1.enable = tv[i].en;
      if (i == 7) begin
        cnt_a = 0;
        quiet = 1;
        for (int k = 0; k < 11; k++) begin
          @(negedge clk);
          if (k == 0) d1 = int'(b1.duty_applied);
          if (b1.in_a) cnt_a++;
        end
        check("drop_duty0", i, d1, tv[i].duty);
        check("drop_ha", i, cnt_a, 11);
        b1.enable = 1'b0;
        @(negedge clk);
        check("drop_in_a", i, int'(b1.in_a), 0);
        check("drop_duty", i, int'(b1.duty_applied), 0);
        for (int k = 12; k < 100; k++) begin
          @(negedge clk);
          if (b1.in_a || b1.in_b) quiet = 0;
        end
        check("drop_quiet", i, quiet, 1);
      end else begin
        run_period();
        check("duty", i, d1, tv[i].duty);
        check("hi_a", i, ha, tv[i].ha);
        check("hi_b", i, hb, tv[i].hb);
        check("first", i, first, tv[i].first);
        check("pstart", i, ps_ok, 1);
        check("overlap", i, ovl, 0);
        if (i < 3) begin
          check("x_duty", i, d2, e2d[i]);
          check("x_hi_b", i, hb2, e2b[i]);
          check("x_hi_a", i, ha2, 0);
        end
      end
    end

    b1.pwmRef = -16'sd10;
    b1.enable = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_b", 20, int'(b1.in_b), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_in_b", 20, int'(b1.in_b), 0);
    check("arst_duty", 20, int'(b1.duty_applied), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_pstart", 21, int'(b1.period_start), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
